// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the select of an upstream CH:1 mux through every
// channel, lets each select settle for SETTLE cycles, samples the mux output
// and publishes the assembled word with a done pulse and a change flag.
module mux_scan_ctrl #(
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cont,
    input  logic                       abort,
    input  logic                       y_in,
    output logic [SEL_W-1:0]           sel,
    output logic                       busy,
    output logic                       done,
    output logic [(1 << SEL_W)-1:0]    data_out,
    output logic                       changed
);

    localparam int unsigned CH    = 1 << SEL_W;
    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state,    state_n;
    logic [SEL_W-1:0]  sel_n;
    logic [CNT_W-1:0]  cnt,      cnt_n;
    logic [CH-1:0]     shadow,   shadow_n;
    logic              busy_n;
    logic              done_n;
    logic [CH-1:0]     data_n;
    logic              changed_n;
    logic [CH-1:0]     word;

    // State and output registers; reset clears everything including the shadow word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            cnt      <= '0;
            shadow   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            changed  <= 1'b0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            cnt      <= cnt_n;
            shadow   <= shadow_n;
            busy     <= busy_n;
            done     <= done_n;
            data_out <= data_n;
            changed  <= changed_n;
        end
    end

    // Next-state logic: settle counting, per-channel sampling, word hand-off, abort.
    always_comb begin
        state_n   = state;
        sel_n     = sel;
        cnt_n     = cnt;
        shadow_n  = shadow;
        busy_n    = busy;
        done_n    = 1'b0;
        data_n    = data_out;
        changed_n = changed;
        // Last channel comes straight from the mux since its shadow bit is not yet written.
        word          = shadow;
        word[CH-1]    = y_in;

        case (state)
            IDLE: begin
                sel_n  = '0;
                cnt_n  = '0;
                busy_n = 1'b0;
                if (start) begin
                    state_n = SCAN;
                    busy_n  = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    sel_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_n         = '0;
                    shadow_n[sel] = y_in;
                    if (sel != SEL_LAST) begin
                        sel_n = sel + SEL_W'(1);
                    end else begin
                        sel_n     = '0;
                        data_n    = word;
                        done_n    = 1'b1;
                        changed_n = (word != data_out);
                        if (!cont) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                sel_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

endmodule
